// File: rtl/vga_pkg.sv
// Shared VGA definitions: colour-mode codes, 640x480@60 timing preset and
// the pixel-format to 24-bit RGB expansion used by the raster generator.
package vga_pkg;

    localparam int CM_RGB332 = 0;
    localparam int CM_RGB565 = 1;
    localparam int CM_RGB888 = 2;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 33;

    // Narrow fields are widened by repeating their MSBs so full-scale codes reach 0xFF.
    function automatic logic [23:0] expand_rgb(input int mode, input logic [23:0] c);
        logic [23:0] rgb;
        rgb = '0;
        case (mode)
            CM_RGB332: rgb = {c[7:5], c[7:5], c[7:6],
                              c[4:2], c[4:2], c[4:3],
                              c[1:0], c[1:0], c[1:0], c[1:0]};
            CM_RGB565: rgb = {c[15:11], c[15:13],
                              c[10:5],  c[10:9],
                              c[4:0],   c[4:2]};
            default:   rgb = c;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Reset-clearable shift register that aligns sync/visible flags with the
// pixel source latency; DEPTH=0 collapses to a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_pipelined.sv
// VGA raster generator that requests pixels PIPE_LAT clocks ahead and delays
// sync/blank to match, so colour from a pipelined source lands on the right pixel.
module vga_timing_pipelined
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FRONT    = VGA640_H_FRONT,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BACK     = VGA640_H_BACK,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FRONT    = VGA640_V_FRONT,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BACK     = VGA640_V_BACK,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int COLOR_MODE = CM_RGB332,
    parameter int COLOR_W    = 8,
    parameter int PIPE_LAT   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [COLOR_W-1:0] color_in,
    output logic               req_valid,
    output logic [9:0]         req_x,
    output logic [9:0]         req_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_count,
    output logic               hsync,
    output logic               vsync,
    output logic               blank_n,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               sync_n,
    output logic               vga_clk
);

    localparam bit COLOR_OK = (COLOR_MODE == CM_RGB332 && COLOR_W == 8)  ||
                              (COLOR_MODE == CM_RGB565 && COLOR_W == 16) ||
                              (COLOR_MODE == CM_RGB888 && COLOR_W == 24);

    generate
        if (!COLOR_OK || PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_bad_params
            $error("vga_timing_pipelined: illegal COLOR_MODE/COLOR_W pair or PIPE_LAT out of 0..15");
        end
    endgenerate

    localparam int CW = 12;
    localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          run;
    logic          h_last;
    logic          v_last;
    logic          visible;
    logic          hs_act;
    logic          vs_act;
    logic          hs_d;
    logic          vs_d;
    logic          vis_d;

    assign run    = enable && !reset;
    assign h_last = (h_count == H_LAST);
    assign v_last = (v_count == V_LAST);

    // Disabling parks the raster at the origin so re-enable starts a clean frame.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_last) begin
            h_count <= '0;
            v_count <= v_last ? '0 : v_count + 1'b1;
        end else begin
            h_count <= h_count + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
        end else if (enable && h_last && v_last) begin
            frame_count <= frame_count + 1'b1;
        end
    end

    assign visible = run && (h_count < H_VIS) && (v_count < V_VIS);
    assign hs_act  = run && (h_count >= HS_START) && (h_count < HS_END);
    assign vs_act  = run && (v_count >= VS_START) && (v_count < VS_END);

    assign req_valid   = visible;
    assign req_x       = visible ? h_count[9:0] : '0;
    assign req_y       = visible ? v_count[9:0] : '0;
    assign line_start  = run && (h_count == '0);
    assign frame_start = line_start && (v_count == '0);

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clock (clock),
        .reset (reset),
        .din   ({hs_act, vs_act, visible}),
        .dout  ({hs_d, vs_d, vis_d})
    );

    // Final register adds the one clock that makes req->DAC latency PIPE_LAT+1.
    always_ff @(posedge clock) begin
        if (reset) begin
            hsync              <= !HS_POL;
            vsync              <= !VS_POL;
            blank_n            <= 1'b0;
            {red, green, blue} <= '0;
        end else begin
            hsync              <= hs_d ? HS_POL : !HS_POL;
            vsync              <= vs_d ? VS_POL : !VS_POL;
            blank_n            <= vis_d;
            {red, green, blue} <= vis_d ? expand_rgb(COLOR_MODE, 24'(color_in)) : 24'h0;
        end
    end

    assign sync_n  = 1'b0;
    assign vga_clk = clock;

endmodule

// File: tb/tb_vga_timing_pipelined.sv
// Bench for vga_timing_pipelined: three builds (RGB332/lat2, RGB888/lat0,
// RGB565/lat5 with active-high syncs) on a reduced raster, scoreboard-checked.
module tb_vga_timing_pipelined;

    localparam int HA = 20, HF = 4, HSW = 6, HB = 5;
    localparam int VA = 6,  VF = 2, VSW = 2, VB = 3;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;
    localparam int ND = 3;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            default: return 5;
        endcase
    endfunction

    function automatic int mode_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit pol_of(input int d);
        return (d == 2);
    endfunction

    function automatic logic [23:0] mask_of(input int d);
        case (mode_of(d))
            0:       return 24'h0000FF;
            1:       return 24'h00FFFF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // Widen an n-bit field at c[lsb +: n] to 8 bits by cycling through its bits MSB-first.
    function automatic logic [7:0] rep(input logic [23:0] c, input int lsb, input int n);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) o[7-i] = c[lsb + n - 1 - (i % n)];
        return o;
    endfunction

    function automatic logic [23:0] model_rgb(input int mode, input logic [23:0] c);
        case (mode)
            0:       return {rep(c, 5, 3), rep(c, 2, 3), rep(c, 0, 2)};
            1:       return {rep(c, 11, 5), rep(c, 5, 6), rep(c, 0, 5)};
            default: return c;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  c0;
    logic [23:0] c1;
    logic [15:0] c2;

    logic        rv [ND];
    logic [9:0]  rx [ND];
    logic [9:0]  ry [ND];
    logic        ls [ND];
    logic        fs [ND];
    logic [15:0] fc [ND];
    logic        hs [ND];
    logic        vs [ND];
    logic        bn [ND];
    logic [7:0]  r  [ND];
    logic [7:0]  g  [ND];
    logic [7:0]  b  [ND];
    logic        sn [ND];
    logic        vc [ND];

    always #5 clk = ~clk;

    vga_timing_pipelined #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_MODE(0), .COLOR_W(8), .PIPE_LAT(2)
    ) dut0 (
        .clock(clk), .reset(reset), .enable(enable), .color_in(c0),
        .req_valid(rv[0]), .req_x(rx[0]), .req_y(ry[0]), .line_start(ls[0]),
        .frame_start(fs[0]), .frame_count(fc[0]), .hsync(hs[0]), .vsync(vs[0]),
        .blank_n(bn[0]), .red(r[0]), .green(g[0]), .blue(b[0]),
        .sync_n(sn[0]), .vga_clk(vc[0])
    );

    vga_timing_pipelined #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_MODE(2), .COLOR_W(24), .PIPE_LAT(0)
    ) dut1 (
        .clock(clk), .reset(reset), .enable(enable), .color_in(c1),
        .req_valid(rv[1]), .req_x(rx[1]), .req_y(ry[1]), .line_start(ls[1]),
        .frame_start(fs[1]), .frame_count(fc[1]), .hsync(hs[1]), .vsync(vs[1]),
        .blank_n(bn[1]), .red(r[1]), .green(g[1]), .blue(b[1]),
        .sync_n(sn[1]), .vga_clk(vc[1])
    );

    vga_timing_pipelined #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_MODE(1), .COLOR_W(16), .PIPE_LAT(5)
    ) dut2 (
        .clock(clk), .reset(reset), .enable(enable), .color_in(c2),
        .req_valid(rv[2]), .req_x(rx[2]), .req_y(ry[2]), .line_start(ls[2]),
        .frame_start(fs[2]), .frame_count(fc[2]), .hsync(hs[2]), .vsync(vs[2]),
        .blank_n(bn[2]), .red(r[2]), .green(g[2]), .blue(b[2]),
        .sync_n(sn[2]), .vga_clk(vc[2])
    );

    int checks = 0;
    int errors = 0;
    int popped = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Frame buffer contents seen by each build's pixel source.
    logic [23:0] fb [ND][VA][HA];
    logic [23:0] hist [ND][16];

    // Pixel source: answers each request exactly PIPE_LAT cycles later.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            for (int k = 15; k > 0; k--) hist[d][k] = hist[d][k-1];
            if (rv[d] && ry[d] < VA && rx[d] < HA) hist[d][0] = fb[d][ry[d]][rx[d]];
            else                                   hist[d][0] = 24'($urandom);
        end
        c0 = hist[0][lat_of(0)][7:0];
        c1 = hist[1][lat_of(1)];
        c2 = hist[2][lat_of(2)][15:0];
    end

    typedef struct {
        int          d;
        int          target;
        bit          vis;
        bit          hsa;
        bit          vsa;
        logic [23:0] rgb;
        int          x;
        int          y;
    } exp_t;

    exp_t sb[$];

    // Reference raster: position is simply cycles since the last restart, mod frame length.
    int mpos = 0;
    int mfc = 0;
    bit prev_run = 1'b0;
    bit prev_rst = 1'b1;

    always @(negedge clk) begin
        if (cyc > 0) begin : model
            int h, v;
            bit run, vis, hsa, vsa;
            exp_t e;
            if (prev_rst)                         mfc = 0;
            else if (prev_run && mpos == FT - 1)  mfc = (mfc + 1) % 65536;
            mpos = prev_run ? (mpos + 1) % FT : 0;
            h = mpos % HT;
            v = mpos / HT;
            run = enable && !reset;
            vis = run && h < HA && v < VA;
            hsa = run && h >= HA + HF && h < HA + HF + HSW;
            vsa = run && v >= VA + VF && v < VA + VF + VSW;
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("d%0d_req_valid", d), 32'(rv[d]), 32'(vis));
                chk($sformatf("d%0d_req_x", d), 32'(rx[d]), vis ? 32'(h) : 32'd0);
                chk($sformatf("d%0d_req_y", d), 32'(ry[d]), vis ? 32'(v) : 32'd0);
                chk($sformatf("d%0d_line_start", d), 32'(ls[d]), 32'(run && h == 0));
                chk($sformatf("d%0d_frame_start", d), 32'(fs[d]), 32'(run && mpos == 0));
                chk($sformatf("d%0d_frame_count", d), 32'(fc[d]), 32'(mfc));
            end
            if (reset) begin
                foreach (sb[i]) begin
                    if (sb[i].target > cyc) begin
                        sb[i].vis = 1'b0;
                        sb[i].hsa = 1'b0;
                        sb[i].vsa = 1'b0;
                        sb[i].rgb = '0;
                    end
                end
            end
            for (int d = 0; d < ND; d++) begin
                e.d      = d;
                e.target = cyc + lat_of(d) + 1;
                e.vis    = vis;
                e.hsa    = hsa;
                e.vsa    = vsa;
                e.rgb    = vis ? model_rgb(mode_of(d), fb[d][v][h]) : 24'h0;
                e.x      = h;
                e.y      = v;
                sb.push_back(e);
            end
            prev_run = run;
            prev_rst = reset;
        end
    end

    // Monitor: retires every expectation due in the current cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].target == cyc) begin
                    int d;
                    d = sb[i].d;
                    chk($sformatf("d%0d_hsync", d), 32'(hs[d]), 32'(sb[i].hsa ? pol_of(d) : !pol_of(d)));
                    chk($sformatf("d%0d_vsync", d), 32'(vs[d]), 32'(sb[i].vsa ? pol_of(d) : !pol_of(d)));
                    chk($sformatf("d%0d_blank_n", d), 32'(bn[d]), 32'(sb[i].vis));
                    chk($sformatf("d%0d_rgb", d), 32'({r[d], g[d], b[d]}), 32'(sb[i].rgb));
                    if (sb[i].vis && sb[i].y == 0 && sb[i].x == 1 && d == 0)
                        chk("rgb332_0x49", 32'({r[d], g[d], b[d]}), 32'h494955);
                    if (sb[i].vis && sb[i].y == 0 && sb[i].x == 2 && d == 0)
                        chk("rgb332_0xE0", 32'({r[d], g[d], b[d]}), 32'hFF0000);
                    if (sb[i].vis && sb[i].y == 0 && sb[i].x == 1 && d == 2)
                        chk("rgb565_0xF800", 32'({r[d], g[d], b[d]}), 32'hFF0000);
                    popped++;
                    sb.delete(i);
                end else if (sb[i].target < cyc) begin
                    chk("sb_stale_entry", 32'(sb[i].target), 32'(cyc));
                    sb.delete(i);
                end
            end
        end
    end

    task automatic wait_pos(input int target, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < FT + 5; i++) begin
            @(posedge clk);
            if (mpos == target) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    int rel;
    int first_rq [ND];
    int first_bn [ND];
    int first_hs [ND];

    initial begin
        for (int d = 0; d < ND; d++)
            for (int y = 0; y < VA; y++)
                for (int x = 0; x < HA; x++)
                    fb[d][y][x] = 24'($urandom) & mask_of(d);
        fb[0][0][1] = 24'h49;
        fb[0][0][2] = 24'hE0;
        fb[2][0][1] = 24'hF800;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d_rst_hsync", d), 32'(hs[d]), 32'(!pol_of(d)));
            chk($sformatf("d%0d_rst_vsync", d), 32'(vs[d]), 32'(!pol_of(d)));
            chk($sformatf("d%0d_rst_blank_n", d), 32'(bn[d]), 32'd0);
            chk($sformatf("d%0d_rst_rgb", d), 32'({r[d], g[d], b[d]}), 32'd0);
            chk($sformatf("d%0d_rst_req_valid", d), 32'(rv[d]), 32'd0);
            chk($sformatf("d%0d_sync_n", d), 32'(sn[d]), 32'd0);
            chk($sformatf("d%0d_vga_clk", d), 32'(vc[d]), 32'(clk));
            first_rq[d] = -1;
            first_bn[d] = -1;
            first_hs[d] = -1;
        end

        @(posedge clk);
        #1 reset = 1'b0;
        rel = cyc;
        for (int k = 0; k <= 2 * FT; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("first_frame_start", 32'(fs[0]), 32'd1);
                chk("first_frame_count", 32'(fc[0]), 32'd0);
            end
            if (k == FT) begin
                chk("frame1_start", 32'(fs[0]), 32'd1);
                chk("frame1_count", 32'(fc[0]), 32'd1);
            end
            if (k == 2 * FT) begin
                chk("frame2_start", 32'(fs[0]), 32'd1);
                chk("frame2_count", 32'(fc[0]), 32'd2);
            end
            for (int d = 0; d < ND; d++) begin
                if (first_rq[d] < 0 && rv[d]) first_rq[d] = cyc;
                if (first_bn[d] < 0 && bn[d]) first_bn[d] = cyc;
                if (first_hs[d] < 0 && hs[d] == pol_of(d)) first_hs[d] = cyc;
            end
        end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d_req_to_blank_latency", d), 32'(first_bn[d] - first_rq[d]), 32'(lat_of(d) + 1));
            chk($sformatf("d%0d_hsync_edge_offset", d), 32'(first_hs[d] - rel - (HA + HF)), 32'(lat_of(d) + 1));
        end

        wait_pos(3 * HT + 10 - 1, "midframe_reset");
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d_inrst_blank_n", d), 32'(bn[d]), 32'd0);
            chk($sformatf("d%0d_inrst_hsync", d), 32'(hs[d]), 32'(!pol_of(d)));
            chk($sformatf("d%0d_inrst_req_valid", d), 32'(rv[d]), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_frame_start", 32'(fs[0]), 32'd1);
        chk("post_reset_frame_count", 32'(fc[0]), 32'd0);

        wait_pos(2 * HT + 7 - 1, "enable_drop");
        #1 enable = 1'b0;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++)
            chk($sformatf("d%0d_disabled_blank_n", d), 32'(bn[d]), 32'd0);
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        chk("reenable_frame_start", 32'(fs[0]), 32'd1);
        chk("reenable_req_valid", 32'(rv[0]), 32'd1);
        chk("reenable_req_xy", 32'({rx[0], ry[0]}), 32'd0);

        for (int k = 0; k < 1500; k++) begin
            @(posedge clk);
            #1;
            enable = ($urandom_range(0, 99) < 96);
            reset  = ($urandom_range(0, 999) < 4);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_activity", 32'(popped > 3000), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
